// File: rtl/present_dec_if.sv
// Handshake and data bundle between a PRESENT-80 decryption core and its requester.
interface present_dec_if;
    logic        decrypt_start;
    logic [63:0] state;
    logic [79:0] keys;
    logic [63:0] result;
    logic        decrypt_end;
    logic        busy;

    modport master (
        output decrypt_start, state, keys,
        input  result, decrypt_end, busy
    );

    modport slave (
        input  decrypt_start, state, keys,
        output result, decrypt_end, busy
    );
endinterface

// File: rtl/present_dec.sv
// Iterative PRESENT-80 decryption: 31-cycle forward key expansion, then 31 inverse rounds.
// Optional K32 cache keyed on the user key is enabled by defining PRESENT_DEC_KEYCACHE_EN.
module present_dec #(
    parameter int ROUNDS = 31
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    present_dec_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] KEYX  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Nibble 0 of each table sits in bits [63:60].
    localparam logic [63:0] SBOX     = 64'hC56B90AD3EF84712;
    localparam logic [63:0] INV_SBOX = 64'h5EF8C12DB463079A;

    if (ROUNDS != 31) begin : g_rounds_check
        $error("present_dec: only ROUNDS = 31 is supported");
    end

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[{~x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX[{~x, 2'b00} +: 4];
    endfunction

    function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ rc;
        r[79:76]   = inv_sbox(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction

    logic [1:0]  fsm;
    logic        start_d;
    logic [4:0]  rc;
    logic [63:0] st_reg;
    logic [79:0] key_reg;
    logic [63:0] result_q;
    logic        trigger;
    logic        cache_hit;
    logic [79:0] cache_k32;

    logic [63:0] mix;
    logic [63:0] unperm;
    logic [63:0] st_next;
    logic [79:0] key_next_fwd;
    logic [79:0] key_prev;

    assign trigger      = bus.decrypt_start & ~start_d & (fsm == IDLE);
    assign mix          = st_reg ^ key_reg[79:16];
    assign key_next_fwd = key_fwd(key_reg, rc);
    assign key_prev     = key_inv(key_reg, rc);

    // Inverse pLayer: output bit i takes the input bit that P sent from position i.
    for (genvar i = 0; i < 64; i++) begin : g_inv_perm
        assign unperm[i] = mix[(i == 63) ? 63 : (16 * i) % 63];
    end

    for (genvar n = 0; n < 16; n++) begin : g_inv_sbox
        assign st_next[n*4 +: 4] = inv_sbox(unperm[n*4 +: 4]);
    end

    assign bus.result      = result_q;
    assign bus.decrypt_end = (fsm == DONE);
    assign bus.busy        = (fsm != IDLE);

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            start_d  <= 1'b0;
            rc       <= '0;
            st_reg   <= '0;
            key_reg  <= '0;
            result_q <= '0;
        end else begin
            start_d <= bus.decrypt_start;
            case (fsm)
                IDLE: begin
                    if (trigger) begin
                        st_reg <= bus.state;
                        if (cache_hit) begin
                            key_reg <= cache_k32;
                            rc      <= 5'd31;
                            fsm     <= ROUND;
                        end else begin
                            key_reg <= bus.keys;
                            rc      <= 5'd1;
                            fsm     <= KEYX;
                        end
                    end
                end
                KEYX: begin
                    key_reg <= key_next_fwd;
                    if (rc == 5'd31) begin
                        fsm <= ROUND;
                    end else begin
                        rc <= rc + 5'd1;
                    end
                end
                ROUND: begin
                    st_reg  <= st_next;
                    key_reg <= key_prev;
                    rc      <= rc - 5'd1;
                    // Final whitening with K1 is folded in so result lands with decrypt_end.
                    if (rc == 5'd1) begin
                        result_q <= st_next ^ key_prev[79:16];
                        fsm      <= DONE;
                    end
                end
                DONE: fsm <= IDLE;
                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef PRESENT_DEC_KEYCACHE_EN
    logic        cache_valid;
    logic [79:0] cache_user_key;
    logic [79:0] pend_user_key;
    logic [79:0] pend_k32;

    assign cache_hit = cache_valid && (bus.keys == cache_user_key);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
        end else if (fsm == DONE) begin
            cache_valid <= 1'b1;
        end
    end

    // NOTE: cache payload carries no reset; cache_valid qualifies every use of it.
    always_ff @(posedge sys_clk) begin
        if (trigger) begin
            pend_user_key <= bus.keys;
            if (cache_hit) begin
                pend_k32 <= cache_k32;
            end
        end
        if (fsm == KEYX && rc == 5'd31) begin
            pend_k32 <= key_next_fwd;
        end
        if (fsm == DONE) begin
            cache_user_key <= pend_user_key;
            cache_k32      <= pend_k32;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_k32 = '0;
`endif
endmodule

// File: tb/tb_present_dec.sv
// Directed bench for present_dec: known PRESENT vectors, handshake corners, reset abort, loopback.
module tb_present_dec;
    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    present_dec_if bus ();

    present_dec #(.ROUNDS(31)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    localparam logic [79:0] KEY_ONES = '1;
    localparam logic [79:0] KEY_ZERO = '0;
    localparam logic [63:0] ALL_ONES = '1;

    int total = 0;
    int bad   = 0;

    logic        cache_valid_m = 1'b0;
    logic [79:0] cache_key_m   = '0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [79:0] k);
`ifdef PRESENT_DEC_KEYCACHE_EN
        return (cache_valid_m && cache_key_m == k) ? 31 : 62;
`else
        return (k === k) ? 62 : 62;
`endif
    endfunction

    // Forward PRESENT-80 reference, written straight from the cipher description.
    function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] sb;
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] k;
        sb = 64'hC56B90AD3EF84712;
        s  = pt;
        k  = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) t[n*4 +: 4] = sb[(15 - int'(s[n*4 +: 4])) * 4 +: 4];
            for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16 * i) % 63] = t[i];
            k          = {k[18:0], k[79:19]};
            k[79:76]   = sb[(15 - int'(k[79:76])) * 4 +: 4];
            k[19:15]   = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic launch(input logic [63:0] ct, input logic [79:0] k);
        @(negedge sys_clk);
        bus.state         = ct;
        bus.keys          = k;
        bus.decrypt_start = 1'b1;
        tick();
    endtask

    task automatic wait_end(output int lat);
        lat = 0;
        while (bus.decrypt_end !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] ct, input logic [79:0] k,
                          input logic [63:0] exp_res, input bit poke_done);
        int lat;
        int want;
        want = exp_lat(k);
        launch(ct, k);
        check({tag, "_busy_rise"}, bus.busy, 1);
        @(negedge sys_clk);
        bus.decrypt_start = 1'b0;
        wait_end(lat);
        check({tag, "_latency"}, lat, want);
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_busy_at_end"}, bus.busy, 1);
        if (poke_done) begin
            @(negedge sys_clk);
            bus.decrypt_start = 1'b1;
        end
        tick();
        check({tag, "_end_fall"}, bus.decrypt_end, 0);
        check({tag, "_busy_fall"}, bus.busy, 0);
        check({tag, "_result_hold"}, bus.result, exp_res);
        if (poke_done) begin
            repeat (5) tick();
            check({tag, "_done_trigger_ignored"}, bus.busy, 0);
            @(negedge sys_clk);
            bus.decrypt_start = 1'b0;
            tick();
        end
        cache_valid_m = 1'b1;
        cache_key_m   = k;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ends;
        int first;
        int want;
        logic [63:0] got;
        logic [63:0] pt;
        logic [63:0] ct;
        logic [79:0] k;

        bus.decrypt_start = 1'b0;
        bus.state         = '0;
        bus.keys          = '0;

        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_result", bus.result, 0);
        check("rst_end", bus.decrypt_end, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        tick();
        check("idle_busy", bus.busy, 0);

        run_op("ones_vec", 64'h3333DCD3213210D2, KEY_ONES, ALL_ONES, 1'b0);
        run_op("zero_pt0", 64'h5579C1387B228445, KEY_ZERO, 64'h0, 1'b0);
        run_op("zero_pt1", 64'hA112FFC72F68417B, KEY_ZERO, ALL_ONES, 1'b1);
        run_op("ks_zero", 64'hE72C46C0F5945049, KEY_ONES, 64'h0, 1'b0);
        run_op("ks_again", 64'h3333DCD3213210D2, KEY_ONES, ALL_ONES, 1'b0);

        // Start held high for 100 cycles must yield exactly one completion.
        want = exp_lat(KEY_ZERO);
        launch(64'h5579C1387B228445, KEY_ZERO);
        ends  = 0;
        first = 0;
        got   = ALL_ONES;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.decrypt_end === 1'b1) begin
                ends++;
                if (ends == 1) begin
                    first = i;
                    got   = bus.result;
                end
            end
        end
        check("hold_end_count", ends, 1);
        check("hold_latency", first, want);
        check("hold_result", got, 64'h0);
        @(negedge sys_clk);
        bus.decrypt_start = 1'b0;
        tick();
        cache_valid_m = 1'b1;
        cache_key_m   = KEY_ZERO;

        // A second rising edge while busy must not disturb the running operation.
        want = exp_lat(KEY_ONES);
        launch(64'h3333DCD3213210D2, KEY_ONES);
        ends  = 0;
        first = 0;
        got   = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge sys_clk);
            bus.decrypt_start = (i == 10);
            tick();
            if (bus.decrypt_end === 1'b1) begin
                ends++;
                if (ends == 1) begin
                    first = i;
                    got   = bus.result;
                end
            end
        end
        check("repulse_end_count", ends, 1);
        check("repulse_latency", first, want);
        check("repulse_result", got, ALL_ONES);
        cache_valid_m = 1'b1;
        cache_key_m   = KEY_ONES;

        // Abort 20 cycles into a run.
        launch(64'h5579C1387B228445, KEY_ZERO);
        @(negedge sys_clk);
        bus.decrypt_start = 1'b0;
        for (int i = 1; i <= 20; i++) tick();
        check("abort_busy_before", bus.busy, 1);
        @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        check("abort_result", bus.result, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_end", bus.decrypt_end, 0);
        cache_valid_m = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        ends = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.decrypt_end === 1'b1) ends++;
        end
        check("abort_no_end", ends, 0);
        check("abort_idle", bus.busy, 0);
        run_op("after_abort", 64'hA112FFC72F68417B, KEY_ZERO, ALL_ONES, 1'b0);

        for (int i = 0; i < 50; i++) begin
            k  = {$urandom(), $urandom(), 16'($urandom())};
            pt = {$urandom(), $urandom()};
            ct = encrypt(pt, k);
            run_op($sformatf("loop%0d", i), ct, k, pt, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
